// File: rtl/floating_div.sv
// floating_div: IEEE-754 single-precision divider, restoring one quotient
// bit per cycle, operands flushed to zero, special values on a fast path.
module floating_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] OperandA,
    input  logic [31:0] OperandB,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out,
    output logic        Exception,
    output logic        NaN,
    output logic        zero_exponent,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        ROUND,
        SPECIAL
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] out_q, out_d;
    logic [3:0]  flg_q, flg_d;
    logic        vld_q, vld_d;
    logic        sign_q, sign_d;
    logic [7:0]  ea_q, ea_d;
    logic [7:0]  eb_q, eb_d;
    logic [23:0] mb_q, mb_d;
    logic [24:0] rem_q, rem_d;
    logic [25:0] quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] spo_q, spo_d;
    logic [3:0]  spf_q, spf_d;

    logic [7:0] ea_in, eb_in;
    logic       a_zero, a_inf, a_nan;
    logic       b_zero, b_inf, b_nan;
    logic       sign_in, special;

    assign ea_in   = OperandA[30:23];
    assign eb_in   = OperandB[30:23];
    assign sign_in = OperandA[31] ^ OperandB[31];
    assign a_zero  = (ea_in == 8'h00);
    assign a_inf   = (ea_in == 8'hFF) && (OperandA[22:0] == 23'd0);
    assign a_nan   = (ea_in == 8'hFF) && (OperandA[22:0] != 23'd0);
    assign b_zero  = (eb_in == 8'h00);
    assign b_inf   = (eb_in == 8'hFF) && (OperandB[22:0] == 23'd0);
    assign b_nan   = (eb_in == 8'hFF) && (OperandB[22:0] != 23'd0);
    assign special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;

    // flag vectors are ordered {Exception, NaN, zero_exponent, div_by_zero}
    logic [31:0] sp_out;
    logic [3:0]  sp_flg;

    always_comb begin
        sp_out = {sign_in, 31'd0};
        sp_flg = 4'b0000;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            sp_out = {sign_in, 8'hFF, 23'h7FFFFF};
            sp_flg = 4'b0100;
        end else if (a_inf) begin
            sp_out = {sign_in, 8'hFF, 23'd0};
            sp_flg = 4'b1000;
        end else if (b_inf) begin
            sp_out = {sign_in, 31'd0};
        end else if (a_zero) begin
            sp_flg = 4'b0010;
        end else if (b_zero) begin
            sp_out = {sign_in, 8'hFF, 23'd0};
            sp_flg = 4'b1001;
        end
    end

    // remainder stays below 2*MB, so a 24-bit difference is exact
    logic        ge;
    logic [23:0] diff;

    assign ge   = rem_q >= {1'b0, mb_q};
    assign diff = rem_q[23:0] - mb_q;

    logic [22:0]       frac_n;
    logic              rb;
    logic signed [9:0] exp_n, exp_r;
    logic [23:0]       frac_r;
    logic [31:0]       nrm_out;
    logic [3:0]        nrm_flg;

    always_comb begin
        if (quo_q[25]) begin
            frac_n = quo_q[24:2];
            rb     = quo_q[1];
            exp_n  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
        end else begin
            frac_n = quo_q[23:1];
            rb     = quo_q[0];
            exp_n  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd126;
        end
        frac_r  = {1'b0, frac_n} + {23'd0, rb};
        exp_r   = exp_n + $signed({9'd0, frac_r[23]});
        nrm_out = {sign_q, exp_r[7:0], frac_r[22:0]};
        nrm_flg = 4'b0000;
        if (exp_r >= 10'sd255) begin
            nrm_out = {sign_q, 8'hFF, 23'd0};
            nrm_flg = 4'b1000;
        end else if (exp_r <= 10'sd0) begin
            nrm_out = {sign_q, 31'd0};
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        flg_d   = flg_q;
        vld_d   = 1'b0;
        sign_d  = sign_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        mb_d    = mb_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        spo_d   = spo_q;
        spf_d   = spf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = sign_in;
                    ea_d    = ea_in;
                    eb_d    = eb_in;
                    mb_d    = {1'b1, OperandB[22:0]};
                    rem_d   = {2'b01, OperandA[22:0]};
                    quo_d   = 26'd0;
                    cnt_d   = 5'd0;
                    spo_d   = sp_out;
                    spf_d   = sp_flg;
                    state_d = special ? SPECIAL : DIVIDE;
                end
            end
            DIVIDE: begin
                if (ge) begin
                    rem_d = {diff, 1'b0};
                end else begin
                    rem_d = {rem_q[23:0], 1'b0};
                end
                quo_d = {quo_q[24:0], ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd25) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                out_d   = nrm_out;
                flg_d   = nrm_flg;
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            SPECIAL: begin
                out_d   = spo_q;
                flg_d   = spf_q;
                vld_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            out_q   <= 32'd0;
            flg_q   <= 4'd0;
            vld_q   <= 1'b0;
            sign_q  <= 1'b0;
            ea_q    <= 8'd0;
            eb_q    <= 8'd0;
            mb_q    <= 24'd0;
            rem_q   <= 25'd0;
            quo_q   <= 26'd0;
            cnt_q   <= 5'd0;
            spo_q   <= 32'd0;
            spf_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            flg_q   <= flg_d;
            vld_q   <= vld_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            mb_q    <= mb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            spo_q   <= spo_d;
            spf_q   <= spf_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = vld_q;
    assign out           = out_q;
    assign Exception     = flg_q[3];
    assign NaN           = flg_q[2];
    assign zero_exponent = flg_q[1];
    assign div_by_zero   = flg_q[0];

endmodule

// File: tb/tb_floating_div.sv
// tb_floating_div: random and directed checks of floating_div against an
// arithmetic quotient model, compared on every falling edge.
module tb_floating_div;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] OperandA = 32'd0;
    logic [31:0] OperandB = 32'd0;
    logic        in_ready, out_valid;
    logic [31:0] out;
    logic        Exception, NaN, zero_exponent, div_by_zero;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    floating_div dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .OperandA     (OperandA),
        .OperandB     (OperandB),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out          (out),
        .Exception    (Exception),
        .NaN          (NaN),
        .zero_exponent(zero_exponent),
        .div_by_zero  (div_by_zero)
    );

    // f = {Exception, NaN, zero_exponent, div_by_zero}
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f,
                                  output int lat);
        logic   s, az, ai, an, bz, bi, bn;
        int     ea, eb, e;
        longint ma, mb, q, frac, rnd;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        az = (ea == 0);
        ai = (ea == 255) && (a[22:0] == 23'd0);
        an = (ea == 255) && (a[22:0] != 23'd0);
        bz = (eb == 0);
        bi = (eb == 255) && (b[22:0] == 23'd0);
        bn = (eb == 255) && (b[22:0] != 23'd0);
        lat = 1;
        f = 4'b0000;
        r = {s, 31'd0};
        if (an || bn || (az && bz) || (ai && bi)) begin
            r = {s, 8'hFF, 23'h7FFFFF};
            f = 4'b0100;
        end else if (ai) begin
            r = {s, 8'hFF, 23'd0};
            f = 4'b1000;
        end else if (bi) begin
            r = {s, 31'd0};
        end else if (az) begin
            f = 4'b0010;
        end else if (bz) begin
            r = {s, 8'hFF, 23'd0};
            f = 4'b1001;
        end else begin
            lat = 27;
            ma = longint'({1'b1, a[22:0]});
            mb = longint'({1'b1, b[22:0]});
            q  = (ma * 33554432) / mb;
            if (q >= 33554432) begin
                frac = (q / 4) % 8388608;
                rnd  = (q / 2) % 2;
                e    = ea - eb + 127;
            end else begin
                frac = (q / 2) % 8388608;
                rnd  = q % 2;
                e    = ea - eb + 126;
            end
            frac = frac + rnd;
            if (frac == 8388608) begin
                frac = 0;
                e = e + 1;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0};
                f = 4'b1000;
            end else if (e <= 0) begin
                r = {s, 31'd0};
            end else begin
                r = {s, 8'(e), 23'(frac)};
            end
        end
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] m;
        int          k;
        k = $urandom_range(0, 11);
        if (k == 0)      e = 8'h00;
        else if (k == 1) e = 8'hFF;
        else if (k == 2) e = 8'($urandom_range(1, 8));
        else if (k == 3) e = 8'($urandom_range(247, 254));
        else             e = 8'($urandom_range(96, 160));
        m = 23'($urandom);
        k = $urandom_range(0, 7);
        if (k == 0)      m = 23'd0;
        else if (k == 1) m = 23'h7FFFFF;
        return {1'($urandom), e, m};
    endfunction

    // Scoreboard: model the edge just passed, then compare every output.
    logic        pend = 1'b0;
    int          due = 0;
    int          edge_n = 0;
    int          m_lat;
    logic [31:0] p_out = 32'd0;
    logic [3:0]  p_flg = 4'd0;
    logic [31:0] e_out = 32'd0;
    logic [3:0]  e_flg = 4'd0;
    logic        e_vld = 1'b0;
    logic        acc;

    initial begin
        forever begin
            @(negedge clk);
            edge_n++;
            if (!rst) begin
                pend  = 1'b0;
                e_vld = 1'b0;
                e_out = 32'd0;
                e_flg = 4'd0;
            end else begin
                acc   = in_valid && !pend;
                e_vld = 1'b0;
                if (pend && edge_n == due) begin
                    e_vld = 1'b1;
                    e_out = p_out;
                    e_flg = p_flg;
                    pend  = 1'b0;
                end
                if (acc) begin
                    model(OperandA, OperandB, p_out, p_flg, m_lat);
                    due  = edge_n + m_lat;
                    pend = 1'b1;
                end
            end
            checks++;
            if (in_ready !== !pend || out_valid !== e_vld || out !== e_out ||
                {Exception, NaN, zero_exponent, div_by_zero} !== e_flg) begin
                fails++;
                $display("FAIL edge_check @%0d: rdy=%b vld=%b out=%h flags=%b, expected rdy=%b vld=%b out=%h flags=%b",
                         edge_n, in_ready, out_valid, out,
                         {Exception, NaN, zero_exponent, div_by_zero},
                         !pend, e_vld, e_out, e_flg);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [35:0] got, input logic [35:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Issue one pair, then poke junk requests while busy until ready returns.
    task automatic op(input logic [31:0] a, input logic [31:0] b);
        tick();
        OperandA = a;
        OperandB = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (in_ready) break;
            in_valid = ($urandom_range(0, 7) == 0);
            OperandA = $urandom;
            OperandB = $urandom;
            tick();
        end
        in_valid = 1'b0;
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL op_timeout: ready=%b, expected 1 within 40 cycles", in_ready);
        end
    endtask

    function automatic logic [35:0] dut_res();
        return {Exception, NaN, zero_exponent, div_by_zero, out};
    endfunction

    logic [31:0] r;
    logic [3:0]  f;
    int          lat;

    initial begin
        model(32'h40C00000, 32'h40000000, r, f, lat);
        chk("model_6_div_2", {f, r}, {4'b0000, 32'h40400000});
        chk("model_6_div_2_lat", 36'(lat), 36'd27);
        model(32'h3F800000, 32'h40400000, r, f, lat);
        chk("model_1_div_3", {f, r}, {4'b0000, 32'h3EAAAAAB});
        model(32'hC0F00000, 32'h40200000, r, f, lat);
        chk("model_neg", {f, r}, {4'b0000, 32'hC0400000});
        model(32'h3F800000, 32'h00000000, r, f, lat);
        chk("model_div0", {f, r}, {4'b1001, 32'h7F800000});
        chk("model_div0_lat", 36'(lat), 36'd1);
        model(32'hFFFFFFFF, 32'h3F800000, r, f, lat);
        chk("model_nan", {f, r}, {4'b0100, 32'hFFFFFFFF});

        repeat (3) tick();
        chk("reset_state", {in_ready, out_valid, dut_res()}, {1'b1, 1'b0, 36'd0});
        rst = 1'b1;

        op(32'h40C00000, 32'h40000000);
        chk("dut_6_div_2", dut_res(), {4'b0000, 32'h40400000});
        op(32'h3F800000, 32'h40400000);
        chk("dut_1_div_3", dut_res(), {4'b0000, 32'h3EAAAAAB});
        op(32'hC0F00000, 32'h40200000);
        chk("dut_neg", dut_res(), {4'b0000, 32'hC0400000});
        op(32'hFFFFFFFF, 32'h3F800000);
        chk("dut_nan", dut_res(), {4'b0100, 32'hFFFFFFFF});
        op(32'h7F000000, 32'h3F000000);
        chk("dut_exp_255", dut_res(), {4'b1000, 32'h7F800000});
        op(32'h00800000, 32'h40000000);
        chk("dut_exp_0", dut_res(), {4'b0000, 32'h00000000});
        op(32'h00800000, 32'h3F800000);
        chk("dut_exp_1", dut_res(), {4'b0000, 32'h00800000});
        op(32'h3F800000, 32'h00000000);
        chk("dut_div0", dut_res(), {4'b1001, 32'h7F800000});

        // abort an in-flight divide with reset
        tick();
        OperandA = 32'h40C00000;
        OperandB = 32'h40000000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("busy_before_reset", 36'(in_ready), 36'd0);
        rst = 1'b0;
        in_valid = 1'b1;
        tick();
        rst = 1'b1;
        in_valid = 1'b0;
        chk("after_abort", {in_ready, out_valid, dut_res()}, {1'b1, 1'b0, 36'd0});
        repeat (35) tick();

        repeat (250) op(rnd_op(), rnd_op());

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
